// File: rtl/spi_led_pkg.sv
// Shared constants and types for the LED-control SPI responder.
package spi_led_pkg;

  localparam logic [7:0] DEF_SLAVE_ADDR  = 8'h08;
  localparam logic [7:0] DEF_CMD_SET_LED = 8'h06;
  localparam logic [7:0] DEF_ID_BYTE     = 8'hA5;

  // Payload of a set-LED frame: led_id, red, green, blue.
  localparam logic [2:0] PAY_BYTES = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_CMD  = 3'd2,
    ST_DATA = 3'd3,
    ST_SKIP = 3'd4
  } state_e;

endpackage

// File: rtl/spi_led_responder_sync.sv
// Two-flop synchronizer with a one-register edge detector for one SPI pin.
// Edges are only reported once the whole chain holds real pin samples, so
// the reset value of the chain can never be mistaken for a pin transition.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic       meta_q;
  logic       sync_q;
  logic       prev_q;
  logic [2:0] fill_q;

  // Synchronizer chain, edge-detect register and chain-fill tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      fill_q <= 3'b000;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  assign level_o = sync_q;
  assign rise_o  = fill_q[2] &  sync_q & ~prev_q;
  assign fall_o  = fill_q[2] & ~sync_q &  prev_q;

endmodule

// File: rtl/spi_led_responder.sv
// SPI mode-0 slave receiving {addr, cmd, led_id, red, green, blue} frames.
// Colour is committed on slave-select release; MISO returns an ID byte and
// then echoes each received byte one byte late.
//
// state | meaning
// IDLE  | waiting for a slave-select fall
// ADDR  | receiving the address byte
// CMD   | address matched, receiving the command byte
// DATA  | set-LED command, filling the four shadow payload bytes
// SKIP  | frame not for us (or bad command), ignoring bytes until release
module spi_led_responder
  import spi_led_pkg::*;
#(
  parameter logic [7:0] SLAVE_ADDR  = DEF_SLAVE_ADDR,
  parameter logic [7:0] CMD_SET_LED = DEF_CMD_SET_LED,
  parameter logic [7:0] ID_BYTE     = DEF_ID_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       ssbar,
  output logic       miso,
  output logic       miso_oe,
  output logic [7:0] led_id,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       led_upd,
  output logic       frame_err,
  output logic       busy
);

  logic sclk_lvl_unused;
  logic sclk_rise;
  logic sclk_fall;
  logic mosi_lvl;
  logic mosi_rise_unused;
  logic mosi_fall_unused;
  logic ss_lvl;
  logic ss_rise;
  logic ss_fall;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk     (clk),
    .rst     (rst),
    .async_i (sclk),
    .level_o (sclk_lvl_unused),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .async_i (mosi),
    .level_o (mosi_lvl),
    .rise_o  (mosi_rise_unused),
    .fall_o  (mosi_fall_unused)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk     (clk),
    .rst     (rst),
    .async_i (ssbar),
    .level_o (ss_lvl),
    .rise_o  (ss_rise),
    .fall_o  (ss_fall)
  );

  state_e     state_q,     state_d;
  logic [2:0] bit_cnt_q,   bit_cnt_d;
  logic [2:0] pay_cnt_q,   pay_cnt_d;
  logic       err_pend_q,  err_pend_d;
  logic [7:0] rx_sr_q,     rx_sr_d;
  logic [7:0] tx_sr_q,     tx_sr_d;
  logic [7:0] echo_q,      echo_d;
  logic       echo_pend_q, echo_pend_d;
  logic [7:0] sh_id_q,     sh_id_d;
  logic [7:0] sh_red_q,    sh_red_d;
  logic [7:0] sh_green_q,  sh_green_d;
  logic [7:0] sh_blue_q,   sh_blue_d;
  logic [7:0] led_id_q,    led_id_d;
  logic [7:0] red_q,       red_d;
  logic [7:0] green_q,     green_d;
  logic [7:0] blue_q,      blue_d;
  logic       led_upd_q,   led_upd_d;
  logic       frame_err_q, frame_err_d;

  logic [7:0] rx_byte;
  logic       byte_done;

  // Byte as it will look once the current sampled bit is shifted in.
  assign rx_byte = {rx_sr_q[6:0], mosi_lvl};

  // State, shift registers, counters and LED outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      pay_cnt_q   <= 3'd0;
      err_pend_q  <= 1'b0;
      rx_sr_q     <= 8'h00;
      tx_sr_q     <= 8'h00;
      echo_q      <= 8'h00;
      echo_pend_q <= 1'b0;
      sh_id_q     <= 8'h00;
      sh_red_q    <= 8'h00;
      sh_green_q  <= 8'h00;
      sh_blue_q   <= 8'h00;
      led_id_q    <= 8'h00;
      red_q       <= 8'h00;
      green_q     <= 8'h00;
      blue_q      <= 8'h00;
      led_upd_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      err_pend_q  <= err_pend_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      echo_q      <= echo_d;
      echo_pend_q <= echo_pend_d;
      sh_id_q     <= sh_id_d;
      sh_red_q    <= sh_red_d;
      sh_green_q  <= sh_green_d;
      sh_blue_q   <= sh_blue_d;
      led_id_q    <= led_id_d;
      red_q       <= red_d;
      green_q     <= green_d;
      blue_q      <= blue_d;
      led_upd_q   <= led_upd_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame FSM: select edges start/commit a frame, SCLK edges move bits.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    err_pend_d  = err_pend_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    echo_d      = echo_q;
    echo_pend_d = echo_pend_q;
    sh_id_d     = sh_id_q;
    sh_red_d    = sh_red_q;
    sh_green_d  = sh_green_q;
    sh_blue_d   = sh_blue_q;
    led_id_d    = led_id_q;
    red_d       = red_q;
    green_d     = green_q;
    blue_d      = blue_q;
    led_upd_d   = 1'b0;
    frame_err_d = 1'b0;
    byte_done   = 1'b0;

    if (ss_fall) begin
      // A fall always restarts the frame, even if SCLK is (illegally) high.
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      pay_cnt_d   = 3'd0;
      err_pend_d  = 1'b0;
      rx_sr_d     = 8'h00;
      tx_sr_d     = ID_BYTE;
      echo_pend_d = 1'b0;
    end else if (ss_rise) begin
      case (state_q)
        ST_DATA: begin
          if (pay_cnt_q == PAY_BYTES) begin
            led_id_d  = sh_id_q;
            red_d     = sh_red_q;
            green_d   = sh_green_q;
            blue_d    = sh_blue_q;
            led_upd_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        ST_CMD:  frame_err_d = 1'b1;
        default: frame_err_d = err_pend_q;
      endcase
      // Any partial byte is dropped with the frame.
      state_d     = ST_IDLE;
      err_pend_d  = 1'b0;
      bit_cnt_d   = 3'd0;
      echo_pend_d = 1'b0;
    end else if ((state_q != ST_IDLE) && !ss_lvl) begin
      if (sclk_rise) begin
        rx_sr_d   = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_done = (bit_cnt_q == 3'd7);
      end

      // The fall after a completed byte loads its echo instead of shifting.
      if (sclk_fall) begin
        if (echo_pend_q) begin
          tx_sr_d     = echo_q;
          echo_pend_d = 1'b0;
        end else begin
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end
      end

      if (byte_done) begin
        echo_d      = rx_byte;
        echo_pend_d = 1'b1;
        case (state_q)
          ST_ADDR: begin
            state_d = (rx_byte == SLAVE_ADDR) ? ST_CMD : ST_SKIP;
          end
          ST_CMD: begin
            if (rx_byte == CMD_SET_LED) begin
              state_d = ST_DATA;
            end else begin
              state_d    = ST_SKIP;
              err_pend_d = 1'b1;
            end
          end
          ST_DATA: begin
            // Trailing padding after the payload is ignored.
            if (pay_cnt_q < PAY_BYTES) begin
              case (pay_cnt_q[1:0])
                2'd0: sh_id_d    = rx_byte;
                2'd1: sh_red_d   = rx_byte;
                2'd2: sh_green_d = rx_byte;
                2'd3: sh_blue_d  = rx_byte;
              endcase
              pay_cnt_d = pay_cnt_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = ~ss_lvl;
  assign miso_oe   = ~ss_lvl;
  assign miso      = miso_oe & tx_sr_q[7];
  assign led_id    = led_id_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign led_upd   = led_upd_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_led_responder.sv
// Directed bench for spi_led_responder: drives SPI frames at 12 clk cycles
// per SCLK phase and checks the committed LED registers, pulses and MISO.
module tb_spi_led_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       mosi;
  logic       ssbar;
  logic       miso;
  logic       miso_oe;
  logic [7:0] led_id;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       led_upd;
  logic       frame_err;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  logic [7:0] fb [8];
  logic [7:0] mb [8];

  spi_led_responder dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .mosi      (mosi),
    .ssbar     (ssbar),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .led_id    (led_id),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .led_upd   (led_upd),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (led_upd) upd_cnt++;
    if (frame_err) err_cnt++;
    if (led_upd && frame_err) both_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (12) @(negedge clk);
      r[7-i] = miso;
      sclk = 1'b1;
      repeat (12) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int nbytes, input int extra_bits, input int gap);
    logic [7:0] dummy;
    ssbar = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < nbytes; k++) send_byte(fb[k], 8, mb[k]);
    if (extra_bits > 0) send_byte(fb[nbytes], extra_bits, dummy);
    repeat (6) @(negedge clk);
    ssbar = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_leds(input string name, input logic [31:0] exp);
    n_checks++;
    if ({led_id, red, green, blue} !== exp) begin
      n_fail++;
      $display("FAIL %s: leds got %h expected %h", name, {led_id, red, green, blue}, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ssbar = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({miso, miso_oe, busy, led_upd, frame_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {miso, miso_oe, busy, led_upd, frame_err});
    end
    check_leds("reset_leds", 32'h0);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_valid_frame();
    int u0, e0;
    logic [7:0] exp_m [8];
    exp_m = '{8'hA5, 8'h08, 8'h06, 8'h04, 8'h10, 8'h1F, 8'h1A, 8'h00};
    fb    = '{8'h08, 8'h06, 8'h04, 8'h10, 8'h1F, 8'h1A, 8'h00, 8'h00};
    u0 = upd_cnt; e0 = err_cnt;
    ssbar = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if ({busy, miso_oe, miso} !== 3'b111) begin
      n_fail++;
      $display("FAIL valid_select: busy/oe/miso got %b expected 111", {busy, miso_oe, miso});
    end
    for (int k = 0; k < 8; k++) send_byte(fb[k], 8, mb[k]);
    repeat (6) @(negedge clk);
    ssbar = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (led_upd !== 1'b0 || red !== 8'h00) begin
      n_fail++;
      $display("FAIL valid_early: led_upd=%b red=%h expected 0 and 00", led_upd, red);
    end
    @(negedge clk);
    n_checks++;
    if (led_upd !== 1'b1) begin
      n_fail++;
      $display("FAIL valid_upd_latency: led_upd got %b expected 1", led_upd);
    end
    check_leds("valid_leds", 32'h04101F1A);
    @(negedge clk);
    n_checks++;
    if (led_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_upd_width: led_upd got %b expected 0", led_upd);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (upd_cnt - u0 !== 1 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL valid_pulses: upd=%0d err=%0d expected 1 and 0", upd_cnt - u0, err_cnt - e0);
    end
    n_checks++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      n_fail++;
      $display("FAIL valid_release: busy/oe/miso got %b expected 000", {busy, miso_oe, miso});
    end
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (mb[k] !== exp_m[k]) begin
        n_fail++;
        $display("FAIL valid_miso[%0d]: got %h expected %h", k, mb[k], exp_m[k]);
      end
    end
  endtask

  task automatic test_wrong_addr();
    int u0, e0;
    logic [7:0] exp_m [6];
    exp_m = '{8'hA5, 8'h09, 8'h06, 8'h44, 8'h55, 8'h66};
    fb    = '{8'h09, 8'h06, 8'h44, 8'h55, 8'h66, 8'h77, 8'h00, 8'h00};
    u0 = upd_cnt; e0 = err_cnt;
    send_frame(6, 0, 20);
    n_checks++;
    if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL addr_pulses: upd=%0d err=%0d expected 0 and 0", upd_cnt - u0, err_cnt - e0);
    end
    check_leds("addr_leds", 32'h04101F1A);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (mb[k] !== exp_m[k]) begin
        n_fail++;
        $display("FAIL addr_miso[%0d]: got %h expected %h", k, mb[k], exp_m[k]);
      end
    end
  endtask

  task automatic test_bad_cmd();
    int u0, e0;
    fb = '{8'h08, 8'h07, 8'h55, 8'h66, 8'h77, 8'h88, 8'h00, 8'h00};
    u0 = upd_cnt; e0 = err_cnt;
    send_frame(6, 0, 20);
    n_checks++;
    if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL cmd_pulses: upd=%0d err=%0d expected 0 and 1", upd_cnt - u0, err_cnt - e0);
    end
    check_leds("cmd_leds", 32'h04101F1A);
  endtask

  task automatic test_short_frame();
    int u0, e0;
    fb = '{8'h08, 8'h06, 8'h77, 8'h88, 8'h99, 8'hAA, 8'h00, 8'h00};
    u0 = upd_cnt; e0 = err_cnt;
    send_frame(4, 0, 20);
    n_checks++;
    if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL short_pulses: upd=%0d err=%0d expected 0 and 1", upd_cnt - u0, err_cnt - e0);
    end
    check_leds("short_leds", 32'h04101F1A);
    u0 = upd_cnt; e0 = err_cnt;
    send_frame(5, 3, 20);
    n_checks++;
    if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 1) begin
      n_fail++;
      $display("FAIL partial_pulses: upd=%0d err=%0d expected 0 and 1", upd_cnt - u0, err_cnt - e0);
    end
    check_leds("partial_leds", 32'h04101F1A);
  endtask

  task automatic test_reset_mid_frame();
    int u0, e0;
    logic [7:0] dummy;
    fb = '{8'h08, 8'h06, 8'h22, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00};
    ssbar = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 4; k++) send_byte(fb[k], 8, mb[k]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({miso, miso_oe, busy, led_upd, frame_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rstmid_ctrl: got %b expected 00000", {miso, miso_oe, busy, led_upd, frame_err});
    end
    check_leds("rstmid_leds", 32'h0);
    u0 = upd_cnt; e0 = err_cnt;
    send_byte(fb[4], 8, dummy);
    send_byte(fb[5], 8, dummy);
    repeat (6) @(negedge clk);
    ssbar = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (upd_cnt - u0 !== 0 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL rstmid_pulses: upd=%0d err=%0d expected 0 and 0", upd_cnt - u0, err_cnt - e0);
    end
    check_leds("rstmid_after", 32'h0);
    fb = '{8'h08, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00};
    u0 = upd_cnt;
    send_frame(6, 0, 20);
    n_checks++;
    if (upd_cnt - u0 !== 1) begin
      n_fail++;
      $display("FAIL rstmid_next_upd: upd=%0d expected 1", upd_cnt - u0);
    end
    check_leds("rstmid_next_leds", 32'h01020304);
  endtask

  task automatic test_back_to_back();
    int u0, e0;
    u0 = upd_cnt; e0 = err_cnt;
    fb = '{8'h08, 8'h06, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h00, 8'h00};
    send_frame(6, 0, 6);
    fb = '{8'h08, 8'h06, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00};
    send_frame(6, 0, 20);
    n_checks++;
    if (upd_cnt - u0 !== 2 || err_cnt - e0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_pulses: upd=%0d err=%0d expected 2 and 0", upd_cnt - u0, err_cnt - e0);
    end
    check_leds("b2b_leds", 32'h11223344);
    n_checks++;
    if (both_cnt !== 0) begin
      n_fail++;
      $display("FAIL upd_err_overlap: got %0d cycles expected 0", both_cnt);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_valid_frame();
    test_wrong_addr();
    test_bad_cmd();
    test_short_frame();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
